// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches instruction pairs ahead of the decoder
// and buffers them in a small FIFO, flushing on ALU redirects.
module ifetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en,
   input  logic [31:0] jump_addr,
   input  logic        stall_in,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata0,
   input  logic [31:0] mem_rdata1,
   output logic        out_valid,
   output logic [31:0] out_ins0,
   output logic [31:0] out_ins1,
   output logic [31:0] out_pc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pend_pc_q, pend_pc_d;
   logic          pend_q, pend_d;
   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0]   fifo_ins0_q [DEPTH];
   logic [31:0]   fifo_ins1_q [DEPTH];
   logic [31:0]   fifo_pc_q   [DEPTH];

   logic [PW+1:0] occupancy;
   logic          has_head;
   logic          push;
   logic          pop;

   always_comb begin
      // In-flight response reserves a slot so a push can never hit a full queue
      occupancy = {1'b0, count_q} + {{(PW+1){1'b0}}, pend_q};
      mem_req   = rst & ~jump_en & (occupancy < DEPTH_W);
      mem_addr  = fetch_pc_q;

      has_head  = rst & (count_q != '0);
      out_valid = has_head & ~jump_en;
      out_ins0  = has_head ? fifo_ins0_q[rd_ptr_q] : '0;
      out_ins1  = has_head ? fifo_ins1_q[rd_ptr_q] : '0;
      out_pc    = has_head ? fifo_pc_q[rd_ptr_q]   : '0;

      push = rst & ~jump_en & pend_q;
      pop  = out_valid & ~stall_in;

      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      pend_d     = pend_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;

      if (!rst) begin
         fetch_pc_d = '0;
         pend_pc_d  = '0;
         pend_d     = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else if (jump_en) begin
         // Flush: the response landing this cycle belongs to the old stream
         fetch_pc_d = jump_addr;
         pend_d     = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (mem_req) begin
            fetch_pc_d = fetch_pc_q + 32'd2;
            pend_pc_d  = fetch_pc_q;
            pend_d     = 1'b1;
         end else begin
            pend_d = 1'b0;
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
         fifo_ins0_q[wr_ptr_q] <= mem_rdata0;
         fifo_ins1_q[wr_ptr_q] <= mem_rdata1;
         fifo_pc_q[wr_ptr_q]   <= pend_pc_q;
      end
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of instruction-pair entries in the prefetch queue (power of two, >= 2).
REQ-002 clk  input  1  clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 jump_en  input  1  redirect request from the ALU stage; 1 = flush and refetch.
REQ-005 jump_addr  input  32  redirect target word address.
REQ-006 stall_in  input  1  decoder backpressure; 1 = decoder will not take a pair this cycle.
REQ-007 mem_req  output  1  instruction memory read request, one pair per request.
REQ-008 mem_addr  output  32  word address of the first word of the requested pair.
REQ-009 mem_rdata0, mem_rdata1  input  32 each  words at mem_addr and mem_addr+1, valid exactly one cycle after the request cycle.
REQ-010 out_valid  output  1  queue head holds a deliverable pair.
REQ-011 out_ins0, out_ins1  output  32 each  queue head instruction pair.
REQ-012 out_pc  output  32  word address of out_ins0.

Function
REQ-013 Internal state: fetch_pc (32), DEPTH-entry FIFO of {ins0, ins1, pc}, count (0..DEPTH), rd/wr pointers, pend flag (a response is due this cycle), pend_pc.
REQ-014 mem_req = rst & ~jump_en & (count + pend < DEPTH), combinational; mem_addr = fetch_pc.
REQ-015 On a request edge: fetch_pc <= fetch_pc + 2 (modulo 2^32, 0xFFFFFFFE wraps to 0x00000000); pend <= 1; pend_pc <= fetch_pc. Without a request: pend <= 0.
REQ-016 Push: when pend = 1 and jump_en = 0, {mem_rdata0, mem_rdata1, pend_pc} is written at wr pointer on the edge.
REQ-017 Outputs are driven from the FIFO head; out_valid = (count != 0) & ~jump_en; out_ins0/out_ins1/out_pc = head entry when count != 0, otherwise 0.
REQ-018 Pop: when out_valid = 1 and stall_in = 0, the head is consumed on the edge.
REQ-019 Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
REQ-020 Push never occurs when full (guaranteed by REQ-014); pop never occurs when empty (guaranteed by REQ-017).
REQ-021 Fetch-to-output latency: request in cycle N, pair pushed at end of N+1, out_valid = 1 in N+2 if the queue was empty.
REQ-022 Sustained throughput: one pair per cycle when stall_in = 0 and no redirect.
REQ-023 Redirect (jump_en = 1 with rst = 1): on that edge count <= 0, pointers <= 0, pend <= 0, fetch_pc <= jump_addr. The response arriving that cycle is discarded. No request or pop occurs that cycle.
REQ-024 After redirect: first request at jump_addr in the next cycle; first pair with out_pc = jump_addr appears two cycles after that.
REQ-025 jump_en held high for several cycles: the queue stays empty and fetch_pc tracks jump_addr each cycle.
REQ-026 stall_in held with a full queue: no requests; head and outputs stable.

Reset
REQ-027 When rst = 0 at an edge: fetch_pc <= 0, count <= 0, pointers <= 0, pend <= 0, pend_pc <= 0.
REQ-028 During and after reset, out_valid = 0, out_ins0 = out_ins1 = out_pc = 0, and mem_req = 0.
REQ-029 Reset has priority over jump_en, push and pop.
REQ-030 Reset mid-operation discards all queued and in-flight pairs.
REQ-031 The first request after release is at address 0, in the first cycle with rst = 1.

Verification
REQ-032 Release reset, stall_in = 0, memory word k = k -> out_pc 0, 2, 4, ... on consecutive cycles from the 3rd cycle after release; ins0/ins1 = (0,1), (2,3), ...
REQ-033 stall_in = 1 for 10 cycles after first out_valid -> exactly DEPTH = 4 pairs queued (pc 0..6); mem_req = 0 while full; on release pcs 0, 2, 4, 6, 8 delivered with no gap or duplicate.
REQ-034 jump_en pulse, jump_addr = 0x100, while queue holds 3 entries -> out_valid = 0 in the jump cycle and the next two cycles; the next delivered out_pc = 0x100; no pre-jump pc delivered afterwards.
REQ-035 Preload fetch_pc via jump_addr = 0xFFFFFFFC -> delivered out_pc sequence 0xFFFFFFFC, 0xFFFFFFFE, 0x00000000.
REQ-036 Assert rst = 0 for one cycle with queue full and pend = 1 -> out_valid = 0 next cycle; first request at address 0; no stale pair delivered.
REQ-037 Random stall_in, 1000 cycles -> delivered out_pc strictly +2 sequential and count never exceeds DEPTH (scoreboard check).
